alu_pipe: RTL

//  Parametrised, registered ALU for the pipelined core's execute stage. Generalises the 8-bit combinational ALU to WIDTH bits.

---
 rtl/alu_pipe.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit execute-stage ALU with a valid/ready handshake,
// carry-chained ADC/SBB and an iterative shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       function_select,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] input_port_data,
    input  logic [WIDTH-1:0] input_port_kb,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             C,
    output logic             Z,
    output logic             V,
    output logic             N
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SL   = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_SR   = 4'b1000;
    localparam logic [3:0] OP_ASR  = 4'b1001;
    localparam logic [3:0] OP_ADC  = 4'b1010;
    localparam logic [3:0] OP_SBB  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_PORT = 4'b1101;
    localparam logic [3:0] OP_KB   = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_f;
    logic               r_c, r_z, r_v, r_n, r_out_valid;

    logic               w_accept, w_load, w_mul_last;
    logic               w_cin, w_bin, w_add_v, w_sub_v, w_slt;
    logic [WIDTH:0]     w_add, w_sub, w_shl, w_shr, w_asr;
    logic [2*WIDTH-1:0] w_mul_sum;
    logic [WIDTH-1:0]   w_alu_f, w_res_f;
    logic               w_alu_c, w_alu_v, w_res_c, w_res_v;

    assign in_ready   = (r_state == S_IDLE) & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    assign w_load     = (w_accept && (function_select != OP_MUL)) || w_mul_last;
    assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Carry-in/borrow-in comes from the C held in the output register.
    assign w_cin   = (function_select == OP_ADC) ? r_c : 1'b0;
    assign w_bin   = (function_select == OP_SBB) ? r_c : 1'b0;
    assign w_add   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, w_cin};
    assign w_sub   = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, w_bin};
    assign w_add_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
    assign w_sub_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
    assign w_slt   = $signed(A) < $signed(B);

    // Shifts carry one guard bit so the last bit shifted out falls out for free.
    assign w_shl = {1'b0, A} << shift;
    assign w_shr = {A, 1'b0} >> shift;
    assign w_asr = $signed({A, 1'b0}) >>> shift;

    always_comb begin
        w_alu_f = '0;
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (function_select)
            OP_ADD, OP_ADC: begin
                w_alu_f = w_add[WIDTH-1:0];
                w_alu_c = w_add[WIDTH];
                w_alu_v = w_add_v;
            end
            OP_SUB, OP_SBB: begin
                w_alu_f = w_sub[WIDTH-1:0];
                w_alu_c = w_sub[WIDTH];
                w_alu_v = w_sub_v;
            end
            OP_CMP: begin
                w_alu_f = {{(WIDTH-1){1'b0}}, w_slt};
                w_alu_c = w_sub[WIDTH];
                w_alu_v = w_sub_v;
            end
            OP_AND:  w_alu_f = A & B;
            OP_OR:   w_alu_f = A | B;
            OP_XOR:  w_alu_f = A ^ B;
            OP_NOT:  w_alu_f = ~A;
            OP_SL: begin
                w_alu_f = w_shl[WIDTH-1:0];
                w_alu_c = w_shl[WIDTH];
            end
            OP_SR: begin
                w_alu_f = w_shr[WIDTH:1];
                w_alu_c = w_shr[0];
            end
            OP_ASR: begin
                w_alu_f = w_asr[WIDTH:1];
                w_alu_c = w_asr[0];
            end
            OP_PORT: w_alu_f = input_port_data;
            OP_KB:   w_alu_f = input_port_kb;
            OP_PASS: w_alu_f = A;
            default: ;
        endcase
    end

    assign w_res_f = w_mul_last ? w_mul_sum[WIDTH-1:0] : w_alu_f;
    assign w_res_c = w_mul_last ? (|w_mul_sum[2*WIDTH-1:WIDTH]) : w_alu_c;
    assign w_res_v = w_mul_last ? 1'b0 : w_alu_v;

    // The final multiply step writes the output register directly so the
    // product lands WIDTH+1 cycles after accept; DONE is only a turnaround.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_f         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_v         <= 1'b0;
            r_n         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (function_select == OP_MUL)) begin
                        r_state  <= S_MUL;
                        r_cnt    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, A};
                        r_mplier <= B;
                        r_acc    <= '0;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_mul_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_f         <= w_res_f;
                r_c         <= w_res_c;
                r_z         <= (w_res_f == '0);
                r_v         <= w_res_v;
                r_n         <= w_res_f[WIDTH-1];
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign F = r_f;
    assign C = r_c;
    assign Z = r_z;
    assign V = r_v;
    assign N = r_n;
endmodule
